// File: rtl/cache_arb.sv
// cache_arb: shares one downstream cache slave port among n upstream cache
// master ports. Requests are granted round-robin, each grant is held until the
// downstream echoes its ID, and misses are parked in a small routing table so
// that deferred responses (including miss-ID callbacks) reach the right port.
// Optional build macro CACHE_ARB_STAT_EN adds output stat: one 32-bit
// acknowledged-grant counter per upstream port.
module cache_arb #(
  parameter int n   = 2,
  parameter int blk = 64,
  parameter int tsz = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [n*8-1:0]     u_rqst,
  input  logic [n*8-1:0]     u_trsc,
  input  logic [n*blk-1:0]   u_strb,
  input  logic [n*64-1:0]    u_addr,
  input  logic [n*blk*8-1:0] u_wdat,
  output logic [n*8-1:0]     u_resp,
  output logic [n*8-1:0]     u_miss,
  output logic [n*64-1:0]    u_ofst,
  output logic [n*blk*8-1:0] u_rdat,
  output logic [7:0]         d_rqst,
  output logic [7:0]         d_trsc,
  output logic [blk-1:0]     d_strb,
  output logic [63:0]        d_addr,
  output logic [blk*8-1:0]   d_wdat,
  input  logic [7:0]         d_resp,
  input  logic [7:0]         d_miss,
  input  logic [63:0]        d_ofst,
  input  logic [blk*8-1:0]   d_rdat,
`ifdef CACHE_ARB_STAT_EN
  output logic [n*32-1:0]    stat,
`endif
  output logic               full
);

  localparam int PW = (n > 1) ? $clog2(n) : 1;
  localparam int TW = (tsz > 1) ? $clog2(tsz) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   gp;
  logic [7:0]      gid;

  // Per-port views of the packed upstream buses
  logic [7:0]       rq_a [n];
  logic [7:0]       tr_a [n];
  logic [blk-1:0]   sb_a [n];
  logic [63:0]      ad_a [n];
  logic [blk*8-1:0] wd_a [n];
  logic [7:0]       rs_a [n];
  logic [7:0]       ms_a [n];
  logic [63:0]      of_a [n];
  logic [blk*8-1:0] rd_a [n];

  logic [n-1:0]    elig;
  logic [PW:0]     rr_sum;
  logic [PW-1:0]   pick;
  logic            pick_vld;

  // Routing table: valid bit, owning port, original request ID, current miss ID
  logic [tsz-1:0]  tv;
  logic [PW-1:0]   tp [tsz];
  logic [7:0]      ti [tsz];
  logic [7:0]      tm [tsz];

  logic            fr_vld;
  logic [TW-1:0]   fr_idx;
  logic            cb_hit;
  logic [TW-1:0]   cb_idx;
  logic            ack;
  logic            cb;

  // Unpack upstream request buses into per-port arrays
  always_comb begin
    for (int p = 0; p < n; p++) begin
      rq_a[p] = u_rqst[p*8 +: 8];
      tr_a[p] = u_trsc[p*8 +: 8];
      sb_a[p] = u_strb[p*blk +: blk];
      ad_a[p] = u_addr[p*64 +: 64];
      wd_a[p] = u_wdat[p*blk*8 +: blk*8];
    end
  end

  // A port is eligible when it requests and its ID is not already parked in the table
  always_comb begin
    elig = '0;
    for (int p = 0; p < n; p++) begin
      elig[p] = (rq_a[p] != 8'h00);
      for (int e = 0; e < tsz; e++) begin
        if (tv[e] && (ti[e] == rq_a[p])) elig[p] = 1'b0;
      end
    end
  end

  // Round-robin search: first eligible port at or after rr, wrapping modulo n
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    rr_sum   = '0;
    for (int k = 0; k < n; k++) begin
      rr_sum = {1'b0, rr} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(n)) rr_sum = rr_sum - (PW+1)'(n);
      if (!pick_vld && elig[rr_sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_sum[PW-1:0];
      end
    end
  end

  // Lowest free slot for allocation, lowest matching slot for callbacks
  always_comb begin
    fr_vld = 1'b0;
    fr_idx = '0;
    cb_hit = 1'b0;
    cb_idx = '0;
    for (int e = 0; e < tsz; e++) begin
      if (!fr_vld && !tv[e]) begin
        fr_vld = 1'b1;
        fr_idx = TW'(e);
      end
      if (!cb_hit && tv[e] && (d_resp != 8'h00) &&
          ((ti[e] == d_resp) || (tm[e] == d_resp))) begin
        cb_hit = 1'b1;
        cb_idx = TW'(e);
      end
    end
  end

  assign ack  = (state == BUSY) && (d_resp == gid);
  assign cb   = cb_hit && !ack;
  assign full = &tv;

  // Downstream follows the granted port's live inputs; a withdrawn request reads as idle
  always_comb begin
    d_rqst = 8'h00;
    d_trsc = 8'h00;
    d_strb = '0;
    d_addr = 64'h0;
    d_wdat = '0;
    if (state == BUSY) begin
      d_rqst = (rq_a[gp] == gid) ? gid : 8'h00;
      d_trsc = tr_a[gp];
      d_strb = sb_a[gp];
      d_addr = ad_a[gp];
      d_wdat = wd_a[gp];
    end
  end

  // Route a grant acknowledge or a table callback to exactly one upstream port
  always_comb begin
    for (int p = 0; p < n; p++) begin
      rs_a[p] = 8'h00;
      ms_a[p] = 8'h00;
      of_a[p] = 64'h0;
      rd_a[p] = '0;
    end
    if (ack) begin
      rs_a[gp] = d_resp;
      ms_a[gp] = d_miss;
      of_a[gp] = d_ofst;
      rd_a[gp] = d_rdat;
    end else if (cb) begin
      rs_a[tp[cb_idx]] = d_resp;
      ms_a[tp[cb_idx]] = d_miss;
      of_a[tp[cb_idx]] = d_ofst;
      rd_a[tp[cb_idx]] = d_rdat;
    end
    for (int p = 0; p < n; p++) begin
      u_resp[p*8 +: 8]         = rs_a[p];
      u_miss[p*8 +: 8]         = ms_a[p];
      u_ofst[p*64 +: 64]       = of_a[p];
      u_rdat[p*blk*8 +: blk*8] = rd_a[p];
    end
  end

  // Grant sequencer: IDLE picks a port, BUSY waits for its ID echo or a withdrawal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= '0;
      gp    <= '0;
      gid   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld && !full) begin
            gp    <= pick;
            gid   <= rq_a[pick];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            rr    <= (gp == PW'(n-1)) ? '0 : gp + PW'(1);
            state <= IDLE;
          end else if (rq_a[gp] != gid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table occupancy: set on a missed acknowledge, cleared by a final callback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv <= '0;
    end else begin
      if (ack && (d_miss != 8'h00) && fr_vld) tv[fr_idx] <= 1'b1;
      if (cb && (d_miss == 8'h00))            tv[cb_idx] <= 1'b0;
    end
  end

  // Table payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    if (ack && (d_miss != 8'h00) && fr_vld) begin
      tp[fr_idx] <= gp;
      ti[fr_idx] <= gid;
      tm[fr_idx] <= d_miss;
    end
    if (cb && (d_miss != 8'h00)) tm[cb_idx] <= d_miss;
  end

`ifdef CACHE_ARB_STAT_EN
  logic [31:0] cnt [n];

  // Per-port acknowledged-grant counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < n; p++) cnt[p] <= 32'h0;
    end else if (ack) begin
      cnt[gp] <= cnt[gp] + 32'd1;
    end
  end

  // Pack the counters onto the stat bus
  always_comb begin
    for (int p = 0; p < n; p++) stat[p*32 +: 32] = cnt[p];
  end
`endif

`ifndef SYNTHESIS
  logic dup;

  // Flag two ports presenting the same nonzero request ID at once
  always_comb begin
    dup = 1'b0;
    for (int p = 0; p < n; p++) begin
      for (int q = p + 1; q < n; q++) begin
        if ((rq_a[p] != 8'h00) && (rq_a[p] == rq_a[q])) dup = 1'b1;
      end
    end
  end

  a_unique_ids: assert property (@(posedge clk) disable iff (!rst) !dup);
`endif

endmodule

// File: doc/cache_arb.md
Name: cache_arb

Overview:
- Shares one downstream cache slave interface (next-level cache or memory) among `n` upstream cache master interfaces, e.g. L1I and L1D in front of a shared L2.
- Grants requests round-robin and holds each grant until the downstream echoes its ID.
- Tracks outstanding misses so that deferred responses, including miss-ID callbacks, are routed back to the issuing port.
- Pure protocol sequencer; no data storage beyond the routing table.

Parameters:
- n, 2, number of upstream ports (2..8)
- blk, 64, cache line size in bytes
- tsz, 8, routing-table entries (outstanding misses)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- u_rqst  in  n*8  request ID per port; 0 = idle
- u_trsc  in  n*8  coherency transaction per port
- u_strb  in  n*blk  write strobe per port
- u_addr  in  n*64  physical address per port
- u_wdat  in  n*blk*8  write data per port
- u_resp  out  n*8  response ID per port
- u_miss  out  n*8  miss ID per port
- u_ofst  out  n*64  offset per port
- u_rdat  out  n*blk*8  read data per port
- d_rqst  out  8  downstream request ID
- d_trsc  out  8  downstream transaction
- d_strb  out  blk  downstream strobe
- d_addr  out  64  downstream address
- d_wdat  out  blk*8  downstream write data
- d_resp  in  8  downstream response ID
- d_miss  in  8  downstream miss ID
- d_ofst  in  64  downstream offset
- d_rdat  in  blk*8  downstream read data
- full  out  1  routing table full

Behaviour:
- Reset (rst=0, async):
  - grant invalid; rr pointer = 0; all table entries invalid.
  - d_rqst = 0; u_resp = 0 and u_miss = 0 on all ports; full = 0.
- Protocol:
  - An upstream holds u_rqst and its payload stable and nonzero until it sees u_resp == u_rqst on its port.
  - IDs are unique across all ports while outstanding; violating this is a simulation assertion failure.
- States:
  - IDLE:
    - Eligible port = u_rqst != 0, and its ID is neither in the table nor the current grant.
    - If any port is eligible and full = 0: register the first eligible port at or after rr, then go to BUSY.
    - Grant latency is 1 cycle from u_rqst to d_rqst.
  - BUSY:
    - d_* is driven from the granted port's live inputs. d_rqst = 0 if that port's u_rqst no longer equals the granted ID.
    - If d_resp == granted ID: forward d_resp, d_miss, d_ofst and d_rdat to the granted port the same cycle. rr ← granted port + 1, modulo n.
      - If d_miss != 0: allocate the lowest free table entry {port, id, miss = d_miss}.
      - Return to IDLE; the next grant is possible in the following cycle.
    - If the granted port changes or withdraws its u_rqst: abandon the grant and return to IDLE with no table write.
- Callbacks (any state):
  - Trigger: d_resp != 0, d_resp is not the granted ID, and it matches a valid entry's id or miss field.
  - If d_miss == 0: forward resp, ofst and rdat to the entry's port with u_miss = 0, and free the entry.
  - If d_miss != 0 (re-miss): update the entry's miss field to d_miss and forward to its port.
  - If d_resp matches no entry and no grant: drop it.
- full = 1 when all tsz entries are valid.
  - Grants are blocked while full = 1.
  - A callback freeing an entry lifts the block in the next cycle.
- Simultaneous events:
  - A grant acknowledge and a callback cannot share a cycle, because there is one d_resp.
  - An allocation and a free in the same cycle may target the same slot only if it was freed in a prior cycle.
- u_resp on non-addressed ports is 0 every cycle. u_ofst and u_rdat are don't-care when u_resp = 0.

Optional Feature:
- Macro: CACHE_ARB_STAT_EN.
- When defined:
  - Adds output stat, width n*32: a per-port 32-bit grant counter.
  - Each counter increments on every acknowledged grant of its port and wraps at 2^32.
  - Counters are cleared by reset.
- When undefined: no stat port and no counters.

Test Plan:
- Single port: u_rqst[0] = 8'h11, addr 0x1000. Expect d_rqst = 8'h11 one cycle later. Downstream responds resp = 8'h11, miss = 0 → u_resp[0] = 8'h11 the same cycle, d_rqst = 0 the next cycle.
- Contention: ports 0/1 assert 8'h21/8'h31 together with rr = 0. Expect 8'h21 granted first, then 8'h31 after its ack. Repeat with rr = 1 → 8'h31 granted first.
- Miss and callback: grant 8'h40, downstream acks with miss = 8'h90 → u_miss[0] = 8'h90 and one entry valid. Later d_resp = 8'h90, miss = 0 → u_resp[0] = 8'h90 with rdat forwarded, entry freed.
- Full: with tsz = 2, two missed requests outstanding → full = 1 and a third pending request gets no d_rqst. Callback frees one entry → third request granted the next cycle.
- Withdraw: port 1 drops u_rqst while granted → d_rqst = 0 next cycle, no table write, port 0 granted afterwards.
- Reset: assert rst = 0 while BUSY with 3 entries valid → d_rqst = 0 immediately (async), full = 0, stale callbacks after release dropped.
